// File: rtl/ram_bytewide.sv
// Single-port synchronous RAM: per-byte write enables, registered read with valid strobe, post-reset clear sweep.
// Optional per-byte even parity storage and checking is enabled by defining RAM_PARITY_EN.
module ram_bytewide #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 8,
    parameter int MEMDEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rdEn,
    input  logic                     wrEn,
    input  logic [AWIDTH-1:0]        Addr,
    input  logic [DWIDTH-1:0]        wrData,
    input  logic [(DWIDTH/8)-1:0]    byteEn,
    output logic [DWIDTH-1:0]        rdData,
    output logic                     rdValid,
    output logic                     busy,
    output logic                     addrErr,
    output logic                     parErr
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int IW     = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [AWIDTH-1:0]   clrPtr;
    logic [DWIDTH-1:0]   mem [MEMDEPTH];
    logic                inRange, clrLast, rdAcc, wrAcc, parMis;
    logic [IW-1:0]       wAddr, cAddr;

    // Widened compare so MEMDEPTH == 2**AWIDTH still works.
    assign inRange = ({1'b0, Addr} < (AWIDTH+1)'(MEMDEPTH));
    assign clrLast = (clrPtr == AWIDTH'(MEMDEPTH - 1));
    assign wAddr   = Addr[IW-1:0];
    assign cAddr   = clrPtr[IW-1:0];
    assign busy    = (state == CLEAR);
    assign wrAcc   = (state == READY) && wrEn;
    assign rdAcc   = (state == READY) && rdEn && !wrEn;

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clrLast) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)              clrPtr <= '0;
        else if (state == CLEAR) clrPtr <= clrPtr + 1'b1;
    end

    // Storage: the sweep owns the array while busy; out-of-range writes never alias.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem[cAddr] <= '0;
            end else if (wrAcc && inRange) begin
                for (int k = 0; k < NBYTES; k++)
                    if (byteEn[k]) mem[wAddr][8*k +: 8] <= wrData[8*k +: 8];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [NBYTES-1:0] parity [MEMDEPTH];

    function automatic logic [NBYTES-1:0] byte_parity(input logic [DWIDTH-1:0] d);
        logic [NBYTES-1:0] p;
        for (int k = 0; k < NBYTES; k++) p[k] = ^d[8*k +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                parity[cAddr] <= '0;
            end else if (wrAcc && inRange) begin
                for (int k = 0; k < NBYTES; k++)
                    if (byteEn[k]) parity[wAddr][k] <= ^wrData[8*k +: 8];
            end
        end
    end

    assign parMis = (byte_parity(mem[wAddr]) != parity[wAddr]);
`else
    assign parMis = 1'b0;
`endif

    // Registered read port; rdData holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdData  <= '0;
            rdValid <= 1'b0;
            addrErr <= 1'b0;
            parErr  <= 1'b0;
        end else begin
            rdValid <= rdAcc;
            addrErr <= (rdAcc || wrAcc) && !inRange;
            parErr  <= rdAcc && inRange && parMis;
            if (rdAcc) rdData <= inRange ? mem[wAddr] : '0;
        end
    end

endmodule
